// File: rtl/cpu_step_sequencer.sv
// Phase sequencer for the single-cycle core: turns a PHASES-deep board-clock counter into
// cpu_clk / pc_en / reg_en, with run, single-step and pause modes, halt-on-ecall and retire counting.
module cpu_step_sequencer #(
    parameter int  PHASES          = 8,
    parameter int  DEBOUNCE_CYCLES = 100000,
    parameter int  CNT_W           = 32,
    localparam int PH_W            = $clog2(PHASES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             resume,
    output logic             cpu_clk,
    output logic             pc_en,
    output logic             reg_en,
    output logic [PH_W-1:0]  phase,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_ZERO = PH_W'(0);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0]  PH_HALF = PH_W'(PHASES / 2);
    localparam logic [PH_W-1:0]  PH_PRE  = PH_W'(PHASES / 2 - 1);
    localparam logic [DB_W-1:0]  DB_ZERO = DB_W'(0);
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [PH_W-1:0] phase_s;
    logic            retire_s;
    logic            en_s;
    logic            resume_q_r;
    logic            resume_edge_s;

    logic            sync1_r;
    logic            sync2_r;
    logic            db_level_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            step_pulse_r;

    // Step button: two-flop synchroniser, stability counter, one-cycle pulse on accepted rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            db_level_r   <= 1'b0;
            db_cnt_r     <= DB_ZERO;
            step_pulse_r <= 1'b0;
        end else begin
            sync1_r      <= step_btn;
            sync2_r      <= sync1_r;
            step_pulse_r <= 1'b0;
            if (sync2_r != db_level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    db_level_r   <= sync2_r;
                    db_cnt_r     <= DB_ZERO;
                    step_pulse_r <= sync2_r;
                end else begin
                    db_cnt_r <= db_cnt_r + DB_ONE;
                end
            end else begin
                db_cnt_r <= DB_ZERO;
            end
        end
    end

    assign resume_edge_s = resume & ~resume_q_r;

    // Next state / next phase; mode and halt_req only matter at instruction boundaries
    always_comb begin
        state_s  = state_r;
        phase_s  = phase;
        retire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_s = PH_ZERO;
                if ((mode == 2'b00) || ((mode == 2'b01) && step_pulse_r)) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (phase == PH_LAST) begin
                    phase_s  = PH_ZERO;
                    retire_s = 1'b1;
                    if (halt_req) begin
                        state_s = ST_HALT;
                    end else if (mode == 2'b00) begin
                        state_s = ST_EXEC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    phase_s = phase + PH_ONE;
                    state_s = ST_EXEC;
                end
            end
            ST_HALT: begin
                phase_s = PH_ZERO;
                if (resume_edge_s || step_pulse_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = PH_ZERO;
            end
        endcase
    end

    // Write-enable window straddles the cpu_clk rising edge
    always_comb begin
        if ((state_s == ST_EXEC) && ((phase_s == PH_PRE) || (phase_s == PH_HALF))) begin
            en_s = 1'b1;
        end else begin
            en_s = 1'b0;
        end
    end

    // Outputs load from next-state values so they line up with phase and never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            phase       <= PH_ZERO;
            instr_count <= {CNT_W{1'b0}};
            resume_q_r  <= 1'b0;
            cpu_clk     <= 1'b0;
            pc_en       <= 1'b0;
            reg_en      <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_r    <= state_s;
            phase      <= phase_s;
            resume_q_r <= resume;
            if (retire_s) begin
                instr_count <= instr_count + CNT_ONE;
            end else begin
                instr_count <= instr_count;
            end
            cpu_clk <= (state_s == ST_EXEC) && (phase_s >= PH_HALF);
            pc_en   <= en_s;
            reg_en  <= en_s;
            running <= (state_s == ST_EXEC);
            halted  <= (state_s == ST_HALT);
        end
    end
endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Bench for cpu_step_sequencer: a cycle model pushes expected outputs every clock edge,
// scenario tasks pop and compare them and add scenario-level checks.
module tb_cpu_step_sequencer;
    localparam int PHASES = 8;
    localparam int DEB    = 4;
    localparam int CW     = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    mode;
    logic          step_btn;
    logic          halt_req;
    logic          resume;
    logic          cpu_clk;
    logic          pc_en;
    logic          reg_en;
    logic [2:0]    phase;
    logic          running;
    logic          halted;
    logic [CW-1:0] instr_count;

    logic [11:0] obs_v;
    logic [11:0] exp_v;
    logic [11:0] sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // model state
    int            m_st;
    int            m_ph;
    int            m_dcnt;
    logic [CW-1:0] m_cnt;
    logic          m_s1, m_s2, m_lvl, m_pulse, m_res_q;

    assign obs_v = {cpu_clk, pc_en, reg_en, phase, running, halted, instr_count};

    cpu_step_sequencer #(.PHASES(PHASES), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .halt_req(halt_req),
        .resume(resume), .cpu_clk(cpu_clk), .pc_en(pc_en), .reg_en(reg_en), .phase(phase),
        .running(running), .halted(halted), .instr_count(instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_dcnt = 0; m_cnt = '0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_pulse = 1'b0; m_res_q = 1'b0;
    endtask

    task automatic model_step();
        logic pulse_now, redge, newp;
        pulse_now = m_pulse;
        redge     = resume && !m_res_q;
        m_res_q   = resume;
        newp      = 1'b0;
        if (m_s2 != m_lvl) begin
            if (m_dcnt == DEB - 1) begin m_lvl = m_s2; m_dcnt = 0; newp = m_s2; end
            else m_dcnt++;
        end else m_dcnt = 0;
        m_s2 = m_s1; m_s1 = step_btn; m_pulse = newp;
        case (m_st)
            0: if (mode == 2'b00 || (mode == 2'b01 && pulse_now)) m_st = 1;
            1: if (m_ph == PHASES - 1) begin
                   m_ph = 0; m_cnt = m_cnt + 1'b1;
                   if (halt_req) m_st = 2;
                   else if (mode != 2'b00) m_st = 0;
               end else m_ph++;
            2: if (redge || pulse_now) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [11:0] model_out();
        logic ex, hl, ck, en;
        ex = (m_st == 1);
        hl = (m_st == 2);
        ck = ex && (m_ph >= PHASES / 2);
        en = ex && (m_ph == PHASES / 2 - 1 || m_ph == PHASES / 2);
        return {ck, en, en, 3'(m_ph), ex, hl, m_cnt};
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        sb_q.push_back(model_out());
    end

    initial forever begin
        @(posedge rst);
        model_reset();
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL reset_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_sb got %h want %h", obs_v, exp_v); end end
            n_chk++;
            if (obs_v !== 12'h000) begin n_fail++; $display("FAIL reset_zero got %h want 000", obs_v); end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL idle_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL idle_sb got %h want %h", obs_v, exp_v); end end
        end
        n_chk++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL idle_paused running=%b want 0", running); end
    endtask

    task automatic test_run();
        logic [9:0] want;
        mode = 2'b00;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL run_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL run_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            want = {(i % 8) >= 4, (i % 8) == 3 || (i % 8) == 4, 3'(i % 8), 1'b1, 4'(i / 8)};
            n_chk++;
            if ({cpu_clk, pc_en, phase, running, instr_count} !== want) begin
                n_fail++; $display("FAIL run_decode cyc %0d got %h want %h", i, {cpu_clk, pc_en, phase, running, instr_count}, want);
            end
        end
        mode = 2'b10;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL run_stop_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL run_stop_sb got %h want %h", obs_v, exp_v); end end
        end
        n_chk++;
        if ({running, instr_count} !== {1'b0, 4'd6}) begin n_fail++; $display("FAIL run_end got run=%b cnt=%0d want 0/6", running, instr_count); end
    endtask

    task automatic test_pause_midinstr();
        int n_pc = 0;
        mode = 2'b00;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL pause_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL pause_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            if (pc_en === 1'b1) n_pc++;
            if (i == 2) mode = 2'b10;
        end
        n_chk++;
        if (n_pc != 2 || running !== 1'b0 || instr_count !== 4'd7) begin
            n_fail++; $display("FAIL pause_end got pc_pulses=%0d run=%b cnt=%0d want 2/0/7", n_pc, running, instr_count);
        end
    endtask

    task automatic test_step();
        int n_run = 0;
        int first_run = -1;
        mode = 2'b01;
        step_btn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL step_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL step_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            if (running === 1'b1) begin n_run++; if (first_run < 0) first_run = i; end
            step_btn = (i + 1 >= 2 && i + 1 <= 11);
        end
        n_chk++;
        if (n_run != 8 || first_run != 8 || instr_count !== 4'd8) begin
            n_fail++; $display("FAIL step_one got exec=%0d first=%0d cnt=%0d want 8/8/8", n_run, first_run, instr_count);
        end
    endtask

    task automatic test_step_in_exec();
        int n_run = 0;
        mode = 2'b00;
        for (int i = 0; i <= 44; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL stepx_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL stepx_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            if (running === 1'b1) n_run++;
            if (i == 0) step_btn = 1'b1;
            if (i == 10) step_btn = 1'b0;
            if (i == 16) mode = 2'b01;
        end
        n_chk++;
        if (n_run != 24 || running !== 1'b0 || instr_count !== 4'd11) begin
            n_fail++; $display("FAIL step_discard got exec=%0d run=%b cnt=%0d want 24/0/11", n_run, running, instr_count);
        end
    endtask

    task automatic test_halt();
        mode = 2'b00;
        for (int i = 0; i <= 48; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL halt_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL halt_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            if (i == 24 || i == 28) begin
                n_chk++;
                if ({halted, running, phase, cpu_clk, instr_count} !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd14}) begin
                    n_fail++; $display("FAIL halt_hold cyc %0d got h=%b r=%b ph=%0d ck=%b cnt=%0d want 1/0/0/0/14", i, halted, running, phase, cpu_clk, instr_count);
                end
            end
            if (i == 30) begin
                n_chk++;
                if ({halted, running} !== 2'b00) begin n_fail++; $display("FAIL halt_resume_idle got h=%b r=%b want 0/0", halted, running); end
            end
            if (i == 31) begin
                n_chk++;
                if ({running, phase} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL halt_resume_exec got r=%b ph=%0d want 1/0", running, phase); end
            end
            if (i == 39) begin
                n_chk++;
                if (instr_count !== 4'd15) begin n_fail++; $display("FAIL halt_after_cnt got %0d want 15", instr_count); end
            end
            if (i == 22) halt_req = 1'b1;
            if (i == 24) halt_req = 1'b0;
            if (i == 29) resume = 1'b1;
            if (i == 32) resume = 1'b0;
            if (i == 34) resume = 1'b1;
            if (i == 39) mode = 2'b10;
        end
        n_chk++;
        if ({running, halted, instr_count} !== {1'b0, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL halt_end got r=%b h=%b cnt=%0d want 0/0/0", running, halted, instr_count);
        end
        resume = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode = 2'b00;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL rstmid_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL rstmid_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
        end
        n_chk++;
        if ({cpu_clk, phase} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL rstmid_pre got ck=%b ph=%0d want 1/5", cpu_clk, phase); end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (obs_v !== 12'h000) begin n_fail++; $display("FAIL rstmid_async got %h want 000", obs_v); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL rstmid_hold_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL rstmid_hold_sb got %h want %h", obs_v, exp_v); end end
        end
        rst = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL rstmid_post_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL rstmid_post_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            if (i == 0) begin
                n_chk++;
                if ({running, phase, cpu_clk, instr_count} !== {1'b1, 3'd0, 1'b0, 4'd0}) begin
                    n_fail++; $display("FAIL rstmid_restart got r=%b ph=%0d ck=%b cnt=%0d want 1/0/0/0", running, phase, cpu_clk, instr_count);
                end
            end
            if (i == 8) begin
                n_chk++;
                if (instr_count !== 4'd1) begin n_fail++; $display("FAIL rstmid_first got cnt=%0d want 1", instr_count); end
                mode = 2'b10;
            end
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL wrap_rst_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrap_rst_sb got %h want %h", obs_v, exp_v); end end
        end
        rst  = 1'b0;
        mode = 2'b00;
        for (int i = 0; i <= 136; i++) begin
            @(negedge clk);
            n_chk++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL wrap_sb empty queue"); end
            else begin exp_v = sb_q.pop_front(); if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrap_sb cyc %0d got %h want %h", i, obs_v, exp_v); end end
            if (i == 127 || i == 128) begin
                n_chk++;
                if (instr_count !== 4'((i / 8) % 16)) begin n_fail++; $display("FAIL wrap_cnt cyc %0d got %0d want %0d", i, instr_count, (i / 8) % 16); end
            end
            if (i == 128) mode = 2'b10;
        end
        n_chk++;
        if ({running, instr_count} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL wrap_end got r=%b cnt=%0d want 0/1", running, instr_count); end
    endtask

    initial begin
        rst      = 1'b1;
        mode     = 2'b10;
        step_btn = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        test_reset();
        test_run();
        test_pause_midinstr();
        test_step();
        test_step_in_exec();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_step_sequencer.md
# cpu_step_sequencer

Parametrised phase sequencer that replaces the fixed 3-bit phase counter driving the single-cycle RISC-V core. It derives `cpu_clk`, the PC-update enable and the register-file write enable from a PHASES-deep counter on the board clock. It adds run, single-step and pause modes, a debounced step button, halt-on-ecall with resume, and a retired-instruction counter. It sits between the board clock/button inputs and the PC, decoder and data-memory instances in the top level.

## Interface
- PHASES, 8: board-clock cycles per instruction; power of two, ≥4.
- DEBOUNCE_CYCLES, 100000: consecutive stable synchronised samples required to accept a step-button level change; ≥1.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  board clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  2  00 run, 01 single-step, 1x pause; synchronous; sampled only at instruction boundaries.
- step_btn  in  1  raw step push-button, asynchronous to clk.
- halt_req  in  1  ecall decoded by controller; synchronous; sampled at phase PHASES-1.
- resume  in  1  synchronous level; its rising edge leaves HALT.
- cpu_clk  out  1  core clock; registered.
- pc_en  out  1  PC update enable; registered.
- reg_en  out  1  register-file write enable; registered.
- phase  out  log2(PHASES)  current phase index.
- running  out  1  high while in EXEC.
- halted  out  1  high while in HALT.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, EXEC, HALT.
- Reset (async, any time, including mid-instruction):
  - State goes to IDLE; phase = 0; instr_count = 0.
  - cpu_clk, pc_en, reg_en, running, halted all 0.
  - Debounce counter and debounced level cleared; synchroniser flops cleared.
- Step button path:
  - step_btn passes through a 2-flop synchroniser.
  - The debounced level changes only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any bounce.
  - A debounced rising edge produces a one-cycle step_pulse.
- IDLE:
  - mode=00 → EXEC.
  - mode=01 with step_pulse → EXEC.
  - mode=1x → stay in IDLE.
  - phase holds at 0.
- EXEC:
  - phase increments each cycle.
  - At phase PHASES-1: instr_count increments, phase wraps to 0, and the next state is chosen by priority:
    - halt_req=1 → HALT;
    - else mode=00 → EXEC, back-to-back with no bubble cycle;
    - else → IDLE.
  - A started instruction always completes all PHASES cycles; mode changes and step pulses during EXEC do not affect it.
  - Step pulses arriving in EXEC are discarded, not queued.
- HALT:
  - phase = 0.
  - Rising edge of resume, or step_pulse → IDLE.
  - The halting instruction has already retired, so the PC points past the ecall and resume does not re-trigger it.
- Output decode. All outputs are flops loaded from the next state and next phase, so they align with `phase` and are glitch-free; cpu_clk is a clean flop output.
  - cpu_clk = 1 iff state=EXEC and phase ≥ PHASES/2.
  - pc_en = reg_en = 1 iff state=EXEC and phase ∈ {PHASES/2-1, PHASES/2}. This window straddles the cpu_clk rising edge.
  - running = (state=EXEC); halted = (state=HALT).

## Timing
- In run mode, one instruction takes exactly PHASES clk cycles.
- cpu_clk has a 50% duty cycle.
- cpu_clk rising edge occurs at the clk edge entering phase PHASES/2.
- IDLE→EXEC takes 1 cycle: the first EXEC cycle has phase=0 and cpu_clk=0.
- Single step, raw step_btn rise (held clean) to the first EXEC cycle: 2 synchroniser + DEBOUNCE_CYCLES + 1 clk cycles.
- instr_count updates on the edge leaving phase PHASES-1; it wraps from all-ones to 0.
- halted asserts on the same edge that instr_count increments for the ecall instruction.
- A resume edge in HALT reaches IDLE next cycle; with mode=00, EXEC follows one cycle later.
- A resume edge outside HALT is ignored.

## Test plan
- PHASES=8, rst released, mode=00, run 40 cycles → running=1; cpu_clk low for phases 0–3 and high for 4–7; pc_en/reg_en high only at phases 3 and 4; instr_count=5 after 40 EXEC cycles.
- PHASES=8, DEBOUNCE_CYCLES=4, mode=01: step_btn bouncing 1,0,1 then held high 10 cycles → exactly one 8-cycle EXEC, instr_count 0→1, then IDLE; a second press during EXEC adds nothing.
- mode=00, halt_req=1 at phase 7 of instruction 3 → instr_count=3, halted=1, phase frozen at 0, cpu_clk=0; resume rise → IDLE then EXEC, instr_count=4 after 8 more cycles.
- mode switched 00→1x at phase 2 → current instruction completes all 8 phases, then IDLE; no further pc_en pulses.
- rst asserted at phase 5 with cpu_clk=1 → all outputs 0 immediately (asynchronous), instr_count=0; after release, a full instruction starts from phase 0.
- CNT_W=4, run 16 instructions → instr_count wraps 15→0 at the 16th boundary.
